// File: rtl/lsu_mem_if_if.sv
// Bundled core-side request/response and data-memory signals of the load/store unit.
// "slave" is the LSU's view; "master" is the core plus memory environment driving it.
interface lsu_mem_if_if #(
  parameter int WIDTH    = 32,
  parameter int BE_WIDTH = WIDTH / 8
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [2:0]          req_funct3;
  logic [WIDTH-1:0]    req_addr;
  logic [WIDTH-1:0]    req_wdata;
  logic                rsp_valid;
  logic [WIDTH-1:0]    rsp_rdata;
  logic                misalign_err;
  logic                stall;
  logic                mem_req;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [BE_WIDTH-1:0] mem_be;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [WIDTH-1:0]    mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, misalign_err, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, misalign_err, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/lsu_mem_if.sv
// RV32I load/store unit: one access at a time over a gnt/rvalid word memory port.
// Optional misalignment trap is enabled by defining LSU_MISALIGN_TRAP_EN.
//
// Handshakes: a request is accepted on a clock edge where req_valid && req_ready
// (req_ready only in IDLE); the memory accepts on mem_req && mem_gnt; load data is
// taken on the first mem_rvalid seen in WAIT; rsp_valid is a single-cycle pulse.
module lsu_mem_if #(
  parameter int WIDTH    = 32,
  parameter int BE_WIDTH = WIDTH / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_if_if.slave   bus,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             req_misaligned;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [WIDTH-1:0] load_fmt;
  logic [BE_WIDTH-1:0] be_fmt;
  logic [WIDTH-1:0] wdata_fmt;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_misaligned = 1'b0;
    case (bus.req_funct3)
      F3_H, F3_HU: req_misaligned = bus.req_addr[0];
      F3_W:        req_misaligned = |bus.req_addr[1:0];
      default:     req_misaligned = 1'b0;
    endcase
  end
`else
  // Without the trap, offending low bits simply fall out of lane selection.
  assign req_misaligned = 1'b0;
`endif

  always_comb begin
    lane_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_half = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      F3_B:    load_fmt = {{(WIDTH-8){lane_byte[7]}}, lane_byte};
      F3_BU:   load_fmt = {{(WIDTH-8){1'b0}}, lane_byte};
      F3_H:    load_fmt = {{(WIDTH-16){lane_half[15]}}, lane_half};
      F3_HU:   load_fmt = {{(WIDTH-16){1'b0}}, lane_half};
      default: load_fmt = bus.mem_rdata;
    endcase
  end

  always_comb begin
    case (funct3_q)
      F3_B: begin
        be_fmt    = BE_WIDTH'(1) << addr_q[1:0];
        wdata_fmt = {(WIDTH/8){wdata_q[7:0]}};
      end
      F3_H: begin
        be_fmt    = BE_WIDTH'(3) << {addr_q[1], 1'b0};
        wdata_fmt = {(WIDTH/16){wdata_q[15:0]}};
      end
      default: begin
        be_fmt    = '1;
        wdata_fmt = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          funct3_d = bus.req_funct3;
          we_d     = bus.req_we;
          wdata_d  = bus.req_wdata;
          err_d    = req_misaligned;
          if (req_misaligned) begin
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.mem_gnt) begin
          if (we_q) begin
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = load_fmt;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.rsp_valid    = (state_q == S_RESP);
  assign bus.rsp_rdata    = rdata_q;
  assign bus.misalign_err = (state_q == S_RESP) && err_q;
  assign bus.stall        = ((state_q == S_IDLE) && bus.req_valid) ||
                            (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.mem_req      = (state_q == S_ISSUE);
  assign bus.mem_we       = (state_q == S_ISSUE) && we_q;
  assign bus.mem_addr     = {addr_q[WIDTH-1:2], 2'b00};
  assign bus.mem_be       = we_q ? be_fmt : '0;
  assign bus.mem_wdata    = wdata_fmt;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed plus random bench for lsu_mem_if with a byte-level reference model.
module tb_lsu_mem_if;
  localparam int WIDTH    = 32;
  localparam int BE_WIDTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_if_if #(.WIDTH(WIDTH), .BE_WIDTH(BE_WIDTH)) bus ();
  logic [1:0] dbg_state;

  lsu_mem_if #(.WIDTH(WIDTH), .BE_WIDTH(BE_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_rsp;
  int n_gnt = 0, n_rsp = 0, exp_gnt = 0, exp_rsp = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.mem_req && bus.mem_gnt) n_gnt <= n_gnt + 1;
      if (bus.rsp_valid) n_rsp <= n_rsp + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'(1 << (a % 4));
      3'd1:    return 4'(3 << (2 * ((a / 2) % 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'd0:    return (w & 32'hFF) * 32'h0101_0101;
      3'd1:    return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic bit m_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) return 1'b1;
    if (f3 == 3'd2 && (a % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // driver: one complete operation; memory grants after gnt_dly wait cycles and
  // returns data rv_dly cycles after the grant. keep leaves req_valid high.
  task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word,
                        input int gnt_dly, input int rv_dly, input bit keep);
    bit trap;
    trap = m_trap(f3, addr);
    exp_q.push_back((trap || we) ? 32'h0 : m_load(f3, addr, word));
    exp_rsp++;
    if (!trap) exp_gnt++;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    #1;
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    check("idle_stall", 32'(bus.stall), 32'd1);
    check("idle_mem_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk);
    if (!trap) begin
      for (int i = 0; i <= gnt_dly; i++) begin
        @(negedge clk);
        bus.mem_gnt = (i == gnt_dly);
        bus.mem_rvalid = !we && (i % 2 == 0);
        bus.mem_rdata = $urandom;
        #1;
        check("issue_req", 32'(bus.mem_req), 32'd1);
        check("issue_we", 32'(bus.mem_we), 32'(we));
        check("issue_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
        check("issue_be", 32'(bus.mem_be), we ? 32'(m_be(f3, addr)) : 32'd0);
        if (we) check("issue_wdata", bus.mem_wdata, m_wdata(f3, wdata));
        check("issue_stall", 32'(bus.stall), 32'd1);
        check("issue_rsp", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1 bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      end
      if (!we) begin
        for (int j = 1; j <= rv_dly; j++) begin
          @(negedge clk);
          bus.mem_rvalid = (j == rv_dly);
          bus.mem_rdata = (j == rv_dly) ? word : $urandom;
          #1;
          check("wait_req", 32'(bus.mem_req), 32'd0);
          check("wait_stall", 32'(bus.stall), 32'd1);
          check("wait_rsp", 32'(bus.rsp_valid), 32'd0);
          @(posedge clk);
          #1 bus.mem_rvalid = 1'b0;
        end
      end
    end
    @(negedge clk);
    #1;
    last_rsp = exp_q.pop_front();
    check("resp_valid", 32'(bus.rsp_valid), 32'd1);
    check("resp_rdata", bus.rsp_rdata, last_rsp);
    check("resp_err", 32'(bus.misalign_err), 32'(trap));
    check("resp_stall", 32'(bus.stall), 32'd0);
    check("resp_ready", 32'(bus.req_ready), 32'd0);
    check("resp_mem_req", 32'(bus.mem_req), 32'd0);
    bus.req_valid = keep;
    @(posedge clk);
    #1;
    if (!keep) begin
      @(negedge clk);
      #1;
      check("post_rsp_low", 32'(bus.rsp_valid), 32'd0);
      check("post_rdata_hold", bus.rsp_rdata, last_rsp);
      check("post_ready", 32'(bus.req_ready), 32'd1);
    end
  endtask

  logic [2:0] ld_f3[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
  logic [2:0] st_f3[4] = '{3'd0, 3'd1, 3'd2, 3'd3};

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.misalign_err), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    rst_n = 1'b1;

    // SB at 0x1003, grant after two wait cycles
    run_op(1'b1, 3'd0, 32'h1003, 32'h0000_00A5, 32'h0, 2, 1, 1'b0);
    check("sb_be_const", 32'(m_be(3'd0, 32'h1003)), 32'h8);

    // load extension from word 0x80FF7F01
    run_op(1'b0, 3'd0, 32'h4001, 32'h0, 32'h80FF_7F01, 0, 1, 1'b0);
    check("lb1_rdata", bus.rsp_rdata, 32'h0000_007F);
    run_op(1'b0, 3'd0, 32'h4003, 32'h0, 32'h80FF_7F01, 0, 1, 1'b0);
    check("lb3_rdata", bus.rsp_rdata, 32'hFFFF_FF80);
    run_op(1'b0, 3'd5, 32'h4002, 32'h0, 32'h80FF_7F01, 0, 1, 1'b0);
    check("lhu2_rdata", bus.rsp_rdata, 32'h0000_80FF);
    run_op(1'b0, 3'd1, 32'h4002, 32'h0, 32'h80FF_7F01, 0, 1, 1'b0);
    check("lh2_rdata", bus.rsp_rdata, 32'hFFFF_80FF);

    // LW with slow grant, slow rvalid and early rvalid pulses during ISSUE
    run_op(1'b0, 3'd2, 32'h5000, 32'h0, 32'hDEAD_BEEF, 4, 3, 1'b0);

    // back-to-back SW then LW with req_valid held high
    run_op(1'b1, 3'd2, 32'h6000, 32'h1234_5678, 32'h0, 0, 1, 1'b1);
    run_op(1'b0, 3'd2, 32'h6004, 32'h0, 32'hCAFE_F00D, 0, 1, 1'b0);

    // misaligned LW
    run_op(1'b0, 3'd2, 32'h2002, 32'h0, 32'h1357_9BDF, 0, 1, 1'b0);

    // reset while waiting for read data; the late rvalid must be ignored
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h3000;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_gnt = 1'b1;
    exp_gnt++;
    @(posedge clk);
    #1 bus.mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_rdata", bus.rsp_rdata, 32'd0);
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA5A5_5A5A;
    @(posedge clk);
    #1 bus.mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("postrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("postrst_state", 32'(dbg_state), 32'd0);
      check("postrst_rdata", bus.rsp_rdata, 32'd0);
    end

    // random traffic
    for (int n = 0; n < 40; n++) begin
      bit we;
      logic [2:0] f3;
      we = 1'($urandom_range(0, 1));
      f3 = we ? st_f3[$urandom_range(0, 3)] : ld_f3[$urandom_range(0, 7)];
      run_op(we, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(1, 3), (n < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    @(negedge clk);
    check("grant_count", 32'(n_gnt), 32'(exp_gnt));
    check("rsp_count", 32'(n_rsp), 32'(exp_rsp));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address, plus store data and funct3 from decode.
- Runs one RV32I load or store against a word-wide data memory, using a grant/rvalid handshake.
- Returns sign- or zero-extended load data toward writeback, and asserts stall so the core holds the PC while a memory access is in flight.

Parameters:
- WIDTH, 32, data path and address width.
- BE_WIDTH, 4, byte enables per memory word (WIDTH/8).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory op requested this cycle.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  WIDTH  effective address (ALUResult).
- req_wdata  in  WIDTH  store data (rs2).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  WIDTH  formatted load data; 0 for stores.
- misalign_err  out  1  qualifies rsp_valid (feature-dependent).
- stall  out  1  hold the core.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  WIDTH  word-aligned address, low 2 bits always 0.
- mem_wdata  out  WIDTH  lane-replicated store data.
- mem_be  out  BE_WIDTH  byte enables; 0 for loads.
- mem_gnt  in  1  request accepted by memory.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  WIDTH  read word.

Behaviour:
- Reset:
  - State returns to IDLE immediately, asynchronously.
  - Registered request fields are cleared.
  - rsp_rdata = 0, rsp_valid = 0, misalign_err = 0, mem_req = 0, stall = 0, req_ready = 1.
  - Reset mid-operation abandons the access; any later mem_gnt or mem_rvalid for it is ignored.
- FSM: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture addr, funct3, we and wdata, then go to ISSUE.
  - Exception: a misaligned request with the feature enabled goes to RESP instead.
- ISSUE:
  - mem_req = 1; mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_gnt.
  - On mem_gnt: a store goes to RESP, a load goes to WAIT.
  - mem_rvalid is ignored in this state.
- WAIT:
  - Hold until mem_rvalid; memory guarantees rvalid no earlier than the cycle after gnt.
  - On rvalid, register the formatted data into rsp_rdata and go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then go to IDLE.
  - req_ready = 0 here, so back-to-back requests have a 1-cycle gap.
- stall = req_valid in IDLE, OR state is ISSUE or WAIT.
  - stall is low in RESP, so the core advances on the rsp_valid cycle.
- Latency, counted from the accept edge:
  - Store with immediate grant: rsp_valid 2 cycles later.
  - Load with immediate grant and rvalid the next cycle: rsp_valid 3 cycles later.
- Store formatting:
  - B: mem_be = 0001 << addr[1:0]; wdata[7:0] replicated into all 4 lanes.
  - H: mem_be = 0011 << (2*addr[1]); wdata[15:0] replicated into both halves.
  - W: mem_be = 1111.
- Load formatting:
  - Select the byte lane by addr[1:0], or the half by addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- Unsupported funct3 (011, 110, 111) is handled as W, with no error.
- Outputs are unchanged between operations: rsp_rdata holds its last value.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Misaligned means: H/HU with addr[0] = 1, or W with addr[1:0] != 00.
- Defined:
  - A misaligned request is accepted but never issued (mem_req stays 0).
  - Next cycle is RESP, with rsp_valid = 1, misalign_err = 1 and rsp_rdata = 0.
  - Aligned operations are unaffected.
- Undefined:
  - misalign_err is tied to 0.
  - Offending low address bits are treated as 0 (H uses addr[1] only; W uses lane 0).

Test Plan:
- Reset/idle: rst_n low mid-WAIT, with mem_rvalid arriving after release -> state IDLE, rsp_valid never asserted, req_ready = 1, rsp_rdata = 0.
- Store byte: SB at addr 0x1003, wdata 0x000000A5, gnt after 2 wait cycles -> mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_addr = 0x1000 held stable 3 cycles, rsp_valid 1 cycle after gnt.
- Load extend: mem word 0x80FF7F01; LB at addr+1 -> 0x0000007F; LB at addr+3 -> 0xFFFFFF80; LHU at addr+2 -> 0x000080FF; LH at addr+2 -> 0xFFFF80FF.
- Handshake: LW with gnt delayed 4 cycles and rvalid 3 cycles after gnt -> stall high throughout, single rsp_valid with rdata = mem_rdata, an early rvalid during ISSUE ignored.
- Back-to-back: SW then LW with req_valid held high -> second accept occurs the cycle after RESP, no dropped or duplicated mem_req.
- Misaligned LW at 0x2002:
  - With LSU_MISALIGN_TRAP_EN: mem_req never rises; rsp_valid and misalign_err rise 1 cycle after accept.
  - Without it: mem_addr = 0x2000; misalign_err = 0.
